// File: rtl/freqmeter_input_conditioner.sv
// freqmeter_input_conditioner: synchronise, glitch-filter, edge-strobe and stuck-detect each raw frequency input
module freqmeter_input_conditioner #(
  parameter int INPUTS_COUNT = 24,
  parameter int FILTER_LEN = 3,
  parameter int STUCK_BITS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [INPUTS_COUNT-1:0] F_raw,
  input  logic [INPUTS_COUNT-1:0] en_i,
  output logic [INPUTS_COUNT-1:0] F_in,
  output logic [INPUTS_COUNT-1:0] rise_o,
  output logic [INPUTS_COUNT-1:0] stuck_o
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);
  localparam logic [STUCK_BITS-1:0] IDLE_MAX = '1;
  logic [INPUTS_COUNT-1:0] s1, s2, en_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
      en_q <= '0;
    end else begin
      s1 <= F_raw;
      s2 <= s1;
      en_q <= en_i;
    end
  genvar i;
  for (i = 0; i < INPUTS_COUNT; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [STUCK_BITS-1:0] idle, idle_nx;
    logic f, r, st, acc;
    assign F_in[i] = f;
    assign rise_o[i] = r;
    assign stuck_o[i] = st;
    // a level change is accepted on the FILTER_LEN-th consecutive differing sample
    always_comb begin
      acc = (s2[i] != f) && (cnt == CNT_MAX);
      idle_nx = acc ? '0 : (idle == IDLE_MAX) ? idle : idle + 1'b1;
    end
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        f <= 1'b0;
        r <= 1'b0;
        st <= 1'b0;
        cnt <= '0;
        idle <= '0;
      end else if (!en_q[i]) begin
        f <= 1'b0;
        r <= 1'b0;
        st <= 1'b0;
        cnt <= '0;
        idle <= '0;
      end else begin
        f <= acc ? s2[i] : f;
        r <= acc & s2[i];
        cnt <= (s2[i] == f || acc) ? '0 : cnt + 1'b1;
        idle <= idle_nx;
        st <= idle_nx == IDLE_MAX;
      end
  end
endmodule

// File: tb/tb_freqmeter_input_conditioner.sv
// tb_freqmeter_input_conditioner: directed scenarios plus randomized traffic against a history-based reference model
module tb_freqmeter_input_conditioner;
  localparam int N = 24;
  localparam int FL = 3;
  localparam int SB = 4;
  localparam int LIM = (1 << SB) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] F_raw = '0;
  logic [N-1:0] en_i = '1;
  logic [N-1:0] F_in, rise_o, stuck_o;
  int checks = 0;
  int errors = 0;

  freqmeter_input_conditioner #(.INPUTS_COUNT(N), .FILTER_LEN(FL), .STUCK_BITS(SB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .F_raw(F_raw), .en_i(en_i),
    .F_in(F_in), .rise_o(rise_o), .stuck_o(stuck_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: a level flips once the last FL enabled samples all disagree with it;
  // idle time is plain elapsed edges since the last flip, capped at the stuck limit.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_en = '0, m_f = '0, m_rise = '0;
  int m_idle[N];
  bit m_hist[N][$];

  initial begin
    for (int c = 0; c < N; c++) m_idle[c] = 0;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        m_s1 = '0; m_s2 = '0; m_en = '0; m_f = '0; m_rise = '0;
        for (int c = 0; c < N; c++) begin
          m_idle[c] = 0;
          m_hist[c].delete();
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          if (!m_en[c]) begin
            m_f[c] = 1'b0; m_rise[c] = 1'b0; m_idle[c] = 0;
            m_hist[c].delete();
          end else begin
            bit acc;
            m_hist[c].push_back(m_s2[c]);
            if (m_hist[c].size() > FL) void'(m_hist[c].pop_front());
            acc = (m_hist[c].size() == FL);
            for (int j = 0; j < m_hist[c].size(); j++) if (m_hist[c][j] == m_f[c]) acc = 1'b0;
            m_rise[c] = acc && !m_f[c];
            if (acc) begin
              m_f[c] = !m_f[c];
              m_idle[c] = 0;
              m_hist[c].delete();
            end else if (m_idle[c] < LIM) m_idle[c]++;
          end
        end
        m_s2 = m_s1; m_s1 = F_raw; m_en = en_i;
      end
    end
  end

  function automatic logic [N-1:0] exp_stuck();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_idle[c] >= LIM;
    return v;
  endfunction

  function automatic logic [N-1:0] pat(input int n);
    logic [14:0] c;
    c = 15'(n);
    return {~c[14:3], c[14:3]};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({F_in, rise_o, stuck_o} !== '0) begin
        errors++;
        $display("FAIL reset_hold F_in=%h rise=%h stuck=%h want 0", F_in, rise_o, stuck_o);
      end
    end
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({F_in, rise_o, stuck_o} !== '0) begin
        errors++;
        $display("FAIL reset_release F_in=%h rise=%h stuck=%h want 0", F_in, rise_o, stuck_o);
      end
    end
  endtask

  task automatic check_latency(input int ch);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (F_in[ch] !== (i >= 4) || rise_o[ch] !== (i == 4)) begin
        errors++;
        $display("FAIL latency ch%0d step%0d F_in=%b rise=%b want %b %b",
                 ch, i, F_in[ch], rise_o[ch], i >= 4, i == 4);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk_i);
    F_raw[0] = 1'b1;
    check_latency(0);
    checks++;
    if (F_in[N-1:1] !== '0) begin
      errors++;
      $display("FAIL latency_others F_in=%h want %h", F_in, 24'h1);
    end
  endtask

  task automatic test_glitch(input int w, input int exp_hi, input int exp_rise);
    int hi = 0, rs = 0;
    @(negedge clk_i);
    F_raw[5] = 1'b1;
    repeat (w) @(negedge clk_i);
    F_raw[5] = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      hi += int'(F_in[5]);
      rs += int'(rise_o[5]);
    end
    checks++;
    if (hi != exp_hi || rs != exp_rise) begin
      errors++;
      $display("FAIL glitch_w%0d high_cycles=%0d rises=%0d want %0d %0d", w, hi, rs, exp_hi, exp_rise);
    end
  endtask

  task automatic test_stuck();
    int t = 0;
    logic prev;
    @(negedge clk_i);
    F_raw[2] = 1'b1;
    while (F_in[2] !== 1'b1 && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (F_in[2] !== 1'b1 || rise_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL stuck_rise F_in=%b rise=%b want 1 1", F_in[2], rise_o[2]);
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      checks++;
      if (stuck_o[2] !== (i >= 15)) begin
        errors++;
        $display("FAIL stuck_assert cycle%0d stuck=%b want %b", i, stuck_o[2], i >= 15);
      end
    end
    F_raw[2] = 1'b0;
    t = 0;
    prev = stuck_o[2];
    @(negedge clk_i);
    while (F_in[2] !== 1'b0 && t < 20) begin
      prev = stuck_o[2];
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (F_in[2] !== 1'b0 || prev !== 1'b1 || stuck_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clear F_in=%b stuck_before=%b stuck=%b want 0 1 0", F_in[2], prev, stuck_o[2]);
    end
  endtask

  task automatic test_enable();
    @(negedge clk_i);
    F_raw[1] = 1'b1;
    repeat (8) @(negedge clk_i);
    checks++;
    if (F_in[1] !== 1'b1) begin
      errors++;
      $display("FAIL enable_pre F_in=%b want 1", F_in[1]);
    end
    en_i[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (F_in[1] !== (i == 0) || rise_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL enable_off step%0d F_in=%b rise=%b want %b 0", i, F_in[1], rise_o[1], i == 0);
      end
    end
    en_i[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (F_in[1] !== (i >= 3) || rise_o[1] !== (i == 3)) begin
        errors++;
        $display("FAIL enable_on step%0d F_in=%b rise=%b want %b %b", i, F_in[1], rise_o[1], i >= 3, i == 3);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk_i);
    F_raw[7] = 1'b1;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({F_in, rise_o, stuck_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset F_in=%h rise=%h stuck=%h want 0", F_in, rise_o, stuck_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    check_latency(7);
  endtask

  task automatic test_square_wave();
    logic [N-1:0] hq[$];
    logic [N-1:0] prev, v;
    int rin[N], rout[N];
    for (int c = 0; c < N; c++) begin rin[c] = 0; rout[c] = 0; end
    @(negedge clk_i);
    F_raw = pat(0);
    repeat (10) @(negedge clk_i);
    for (int k = 0; k < 5; k++) hq.push_back(pat(0));
    prev = pat(0);
    for (int n = 0; n < 2048; n++) begin
      @(negedge clk_i);
      checks++;
      if (F_in !== hq[0]) begin
        errors++;
        $display("FAIL square_delay n=%0d F_in=%h want %h", n, F_in, hq[0]);
      end
      void'(hq.pop_front());
      checks++;
      if (rise_o !== m_rise || stuck_o !== exp_stuck()) begin
        errors++;
        $display("FAIL square_model n=%0d rise=%h stuck=%h want %h %h", n, rise_o, stuck_o, m_rise, exp_stuck());
      end
      for (int c = 0; c < N; c++) rout[c] += int'(rise_o[c]);
      v = pat(n + 1);
      for (int c = 0; c < N; c++) rin[c] += int'(v[c] & ~prev[c]);
      prev = v;
      F_raw = v;
      hq.push_back(v);
    end
    repeat (8) begin
      @(negedge clk_i);
      for (int c = 0; c < N; c++) rout[c] += int'(rise_o[c]);
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (rout[c] != rin[c]) begin
        errors++;
        $display("FAIL square_rises ch%0d got=%0d want %0d", c, rout[c], rin[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, e;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      checks++;
      if (F_in !== m_f || rise_o !== m_rise || stuck_o !== exp_stuck()) begin
        errors++;
        $display("FAIL random n=%0d F_in=%h rise=%h stuck=%h want %h %h %h",
                 n, F_in, rise_o, stuck_o, m_f, m_rise, exp_stuck());
      end
      a = $urandom & $urandom;
      e = $urandom & $urandom & $urandom & $urandom & $urandom & $urandom;
      if ((n / 100) % 3 != 2) F_raw ^= a[N-1:0];
      en_i ^= e[N-1:0];
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch(2, 0, 0);
    test_glitch(3, 3, 1);
    test_stuck();
    test_enable();
    test_mid_reset();
    test_square_wave();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
